f2_image_sequencer: RTL and testbench

Frame-synchronous controller for the image display path. Takes debounced navigation buttons and the auto switch, and decides which ROM image, rotation and inversion the display processor uses. All changes are committed only at frame boundaries, so a frame never shows a mix of old and new settings. Sits between the debouncers / VGA timing generator and the display processor / image ROM.

---
 rtl/f2_image_sequencer_pkg.sv | 17 +
 rtl/f2_edge_detect.sv | 26 ++
 rtl/f2_image_sequencer.sv | 167 ++++++++++++++++
 tb/tb_f2_image_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/f2_image_sequencer_pkg.sv
// Shared definitions for the frame-synchronous image sequencer.
package f2_image_sequencer_pkg;

   typedef enum logic [1:0] {
      MANUAL     = 2'd0,
      AUTO_RUN   = 2'd1,
      AUTO_PAUSE = 2'd2
   } seq_state_e;

   localparam int DEF_FRAMES_PER_STEP = 60;
   localparam int DEF_PAUSE_FRAMES    = 180;

   // Widths of the image index and rotation buses seen by the ROM / display
   localparam int IMG_W = 2;
   localparam int ROT_W = 2;

endpackage

// File: rtl/f2_edge_detect.sv
// Single-bit rising-edge detector. The first cycle after reset is masked so a
// level already high when reset releases is not reported as an edge.
module f2_edge_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   output logic pulse_o
);

   logic prev_q;
   logic armed_q;

   // Track previous level; arm only after the first post-reset sample
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         prev_q  <= level_i;
         armed_q <= 1'b1;
      end
   end

   assign pulse_o = level_i & ~prev_q & armed_q;

endmodule

// File: rtl/f2_image_sequencer.sv
// Frame-synchronous image/rotation/inversion controller. Button edges are
// collected into a pending set and committed only on frame_tick, together
// with the slideshow advance from the MANUAL / AUTO_RUN / AUTO_PAUSE FSM.
module f2_image_sequencer
   import f2_image_sequencer_pkg::*;
#(
   parameter int NUM_IMAGES      = 4,
   parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
   parameter int PAUSE_FRAMES    = DEF_PAUSE_FRAMES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic             forwards,
   input  logic             backwards,
   input  logic             rotate,
   input  logic             inverse,
   input  logic             auto,
   output logic [IMG_W-1:0] current_img,
   output logic [ROT_W-1:0] rotation,
   output logic             inverted,
   output logic             auto_active
);

   localparam int CNT_MAX = (FRAMES_PER_STEP > PAUSE_FRAMES) ? FRAMES_PER_STEP : PAUSE_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
   localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);

   // Reduce a 3-bit image sum (range -1..4, -1 encoded as 7) into 0..NUM_IMAGES-1
   function automatic logic [IMG_W-1:0] wrap_img(input logic [2:0] s);
      logic [IMG_W-1:0] r;
      if (s == 3'd7)
         r = IMG_W'(NUM_IMAGES - 1);
      else if (32'(s) >= NUM_IMAGES)
         r = IMG_W'(32'(s) - NUM_IMAGES);
      else
         r = s[IMG_W-1:0];
      return r;
   endfunction

   logic fwd_cmd, bwd_cmd, rot_cmd, inv_cmd;

   f2_edge_detect u_fwd (.clk_i(clk), .rst_i(reset), .level_i(forwards),  .pulse_o(fwd_cmd));
   f2_edge_detect u_bwd (.clk_i(clk), .rst_i(reset), .level_i(backwards), .pulse_o(bwd_cmd));
   f2_edge_detect u_rot (.clk_i(clk), .rst_i(reset), .level_i(rotate),    .pulse_o(rot_cmd));
   f2_edge_detect u_inv (.clk_i(clk), .rst_i(reset), .level_i(inverse),   .pulse_o(inv_cmd));

   seq_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic signed [1:0]  pend_step_q, pend_step_d;
   logic [ROT_W-1:0]   pend_rot_q, pend_rot_d;
   logic               pend_inv_q, pend_inv_d;
   logic               any_cmd_q, any_cmd_d;
   logic [IMG_W-1:0]   img_q, img_d;
   logic [ROT_W-1:0]   rot_q, rot_d;
   logic               inv_q, inv_d;
   logic               auto_active_q;
   logic               auto_step;
   logic [2:0]         img_sum;

   // Pending set: cleared on a tick, then this cycle's edges are loaded on top
   always_comb begin
      pend_step_d = frame_tick ? 2'sd0 : pend_step_q;
      pend_rot_d  = frame_tick ? '0 : pend_rot_q;
      pend_inv_d  = frame_tick ? 1'b0 : pend_inv_q;
      any_cmd_d   = frame_tick ? 1'b0 : any_cmd_q;
      if (fwd_cmd && bwd_cmd)
         pend_step_d = 2'sd0;
      else if (fwd_cmd)
         pend_step_d = 2'sd1;
      else if (bwd_cmd)
         pend_step_d = -2'sd1;
      pend_rot_d = pend_rot_d + ROT_W'(rot_cmd);
      pend_inv_d = pend_inv_d ^ inv_cmd;
      any_cmd_d  = any_cmd_d | fwd_cmd | bwd_cmd | rot_cmd | inv_cmd;
   end

   // Mode FSM and frame counter, advanced only on frame_tick
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      auto_step = 1'b0;
      if (frame_tick) begin
         cnt_d = cnt_q + CNT_W'(1);
         case (state_q)
            MANUAL: begin
               if (auto) begin
                  state_d = AUTO_RUN;
                  cnt_d   = '0;
               end
            end
            AUTO_RUN: begin
               auto_step = (cnt_q == STEP_LAST) && !any_cmd_q;
               if (auto_step)
                  cnt_d = '0;
               if (!auto) begin
                  state_d = MANUAL;
               end else if (any_cmd_q) begin
                  state_d = AUTO_PAUSE;
                  cnt_d   = '0;
               end
            end
            AUTO_PAUSE: begin
               if (!auto) begin
                  state_d = MANUAL;
               end else if (any_cmd_q) begin
                  cnt_d = '0;
               end else if (cnt_q == PAUSE_LAST) begin
                  state_d = AUTO_RUN;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = MANUAL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Commit of the pending set plus any slideshow step at the frame boundary
   always_comb begin
      img_sum = 3'({1'b0, img_q}) + {pend_step_q[1], pend_step_q} + 3'(auto_step);
      img_d   = img_q;
      rot_d   = rot_q;
      inv_d   = inv_q;
      if (frame_tick) begin
         img_d = wrap_img(img_sum);
         rot_d = rot_q + pend_rot_q;
         inv_d = inv_q ^ pend_inv_q;
      end
   end

   // All state and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= MANUAL;
         cnt_q         <= '0;
         pend_step_q   <= 2'sd0;
         pend_rot_q    <= '0;
         pend_inv_q    <= 1'b0;
         any_cmd_q     <= 1'b0;
         img_q         <= '0;
         rot_q         <= '0;
         inv_q         <= 1'b0;
         auto_active_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pend_step_q   <= pend_step_d;
         pend_rot_q    <= pend_rot_d;
         pend_inv_q    <= pend_inv_d;
         any_cmd_q     <= any_cmd_d;
         img_q         <= img_d;
         rot_q         <= rot_d;
         inv_q         <= inv_d;
         auto_active_q <= (state_d == AUTO_RUN);
      end
   end

   assign current_img = img_q;
   assign rotation    = rot_q;
   assign inverted    = inv_q;
   assign auto_active = auto_active_q;

endmodule

// File: tb/tb_f2_image_sequencer.sv
// Directed table-driven bench for f2_image_sequencer (FRAMES_PER_STEP=4,
// PAUSE_FRAMES=3 so slideshow behaviour fits in a short run).
module tb_f2_image_sequencer;

   logic       clk;
   logic       reset;
   logic       frame_tick, forwards, backwards, rotate, inverse, auto;
   logic [1:0] current_img, rotation;
   logic       inverted, auto_active;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       tick, f, b, r, i, a;
      logic [1:0] img, rot;
      logic       inv, act;
   } vec_t;

   vec_t vq[$];

   f2_image_sequencer #(
      .NUM_IMAGES     (4),
      .FRAMES_PER_STEP(4),
      .PAUSE_FRAMES   (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .forwards   (forwards),
      .backwards  (backwards),
      .rotate     (rotate),
      .inverse    (inverse),
      .auto       (auto),
      .current_img(current_img),
      .rotation   (rotation),
      .inverted   (inverted),
      .auto_active(auto_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input logic t, f, b, r, i, a,
                               input logic [1:0] img, rot, input logic inv, act);
      vec_t v;
      v.tick = t; v.f = f; v.b = b; v.r = r; v.i = i; v.a = a;
      v.img = img; v.rot = rot; v.inv = inv; v.act = act;
      vq.push_back(v);
   endfunction

   task automatic check(input string nm, input logic [1:0] eimg, erot, input logic einv, eact);
      checks++;
      if (current_img !== eimg || rotation !== erot || inverted !== einv || auto_active !== eact) begin
         errors++;
         $display("FAIL %s: got img=%0d rot=%0d inv=%0d act=%0d, want img=%0d rot=%0d inv=%0d act=%0d",
                  nm, current_img, rotation, inverted, auto_active, eimg, erot, einv, eact);
      end
   endtask

   task automatic apply(input string nm, input logic t, f, b, r, i, a,
                        input logic [1:0] img, rot, input logic inv, act);
      frame_tick = t; forwards = f; backwards = b; rotate = r; inverse = i; auto = a;
      @(posedge clk);
      #1;
      check(nm, img, rot, inv, act);
   endtask

   initial begin
      reset = 1'b1;
      frame_tick = 0; forwards = 0; backwards = 0; rotate = 0; inverse = 0; auto = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 2'd0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // ---- vector table ----
      add(0,0,0,0,0,0, 0,0,0,0);
      for (int k = 1; k <= 4; k++) begin
         add(0,1,0,0,0,0, 2'(k-1),0,0,0);
         add(1,0,0,0,0,0, 2'(k),0,0,0);      // 1,2,3 then wrap to 0
      end
      add(0,0,1,0,0,0, 0,0,0,0);
      add(1,0,0,0,0,0, 3,0,0,0);             // 0 - 1 wraps to 3
      add(1,0,0,0,0,0, 3,0,0,0);             // pending cleared, no repeat
      add(0,1,1,0,0,0, 3,0,0,0);             // fwd+bwd together
      add(1,0,0,0,0,0, 3,0,0,0);
      add(0,1,0,0,0,0, 3,0,0,0);             // fwd then bwd: latest wins
      add(0,0,1,0,0,0, 3,0,0,0);
      add(1,0,0,0,0,0, 2,0,0,0);
      for (int j = 0; j < 5; j++) begin
         add(0,0,0,1,0,0, 2,0,0,0);
         add(0,0,0,0,0,0, 2,0,0,0);
      end
      add(1,0,0,0,0,0, 2,1,0,0);             // 5 rotates -> 1
      add(1,0,0,0,1,0, 2,1,0,0);             // inverse edge on tick: deferred
      add(0,0,0,0,0,0, 2,1,0,0);
      add(1,0,0,0,0,0, 2,1,1,0);
      for (int j = 0; j < 2; j++) begin
         add(0,0,0,0,1,0, 2,1,1,0);
         add(0,0,0,0,0,0, 2,1,1,0);
      end
      add(1,0,0,0,0,0, 2,1,1,0);             // two inverse edges cancel
      add(0,0,0,0,0,1, 2,1,1,0);             // auto pulse between ticks
      add(1,0,0,0,0,0, 2,1,1,0);
      add(1,0,0,0,0,1, 2,1,1,1);             // enter AUTO_RUN
      for (int k = 1; k <= 15; k++) begin
         logic [1:0] ei;
         ei = (k < 4) ? 2'd2 : (k < 8) ? 2'd3 : (k < 12) ? 2'd0 : 2'd1;
         add(1,0,0,0,0,1, ei,1,1,1);
         add(0,0,0,0,0,1, ei,1,1,1);
      end
      add(0,0,0,1,0,1, 1,1,1,1);             // rotate in AUTO_RUN at cnt=3
      add(0,0,0,0,0,1, 1,1,1,1);
      add(1,0,0,0,0,1, 1,2,1,0);             // pause, no auto step
      add(1,0,0,0,0,1, 1,2,1,0);
      add(0,0,0,1,0,1, 1,2,1,0);             // second edge mid-pause
      add(0,0,0,0,0,1, 1,2,1,0);
      add(1,0,0,0,0,1, 1,3,1,0);             // pause restarted
      add(1,0,0,0,0,1, 1,3,1,0);
      add(1,0,0,0,0,1, 1,3,1,0);
      add(1,0,0,0,0,1, 1,3,1,1);             // back to AUTO_RUN
      add(1,0,0,0,0,1, 1,3,1,1);
      add(1,0,0,0,0,1, 1,3,1,1);
      add(1,0,0,0,0,1, 1,3,1,1);
      add(1,0,0,0,0,1, 2,3,1,1);             // first step after pause

      foreach (vq[n])
         apply($sformatf("vec%0d", n), vq[n].tick, vq[n].f, vq[n].b, vq[n].r, vq[n].i, vq[n].a,
               vq[n].img, vq[n].rot, vq[n].inv, vq[n].act);

      // ---- asynchronous reset mid-AUTO_RUN, forwards held through release ----
      #2;
      reset = 1'b1; forwards = 1'b1; auto = 1'b0; frame_tick = 1'b0;
      #1;
      check("async_reset", 2'd0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      apply("held_fwd_tick1", 1,1,0,0,0,0, 0,0,0,0);
      apply("held_fwd_idle",  0,1,0,0,0,0, 0,0,0,0);
      apply("held_fwd_tick2", 1,1,0,0,0,0, 0,0,0,0);
      apply("release_fwd",    0,0,0,0,0,0, 0,0,0,0);
      apply("post_rst_edge",  0,1,0,0,0,0, 0,0,0,0);
      apply("post_rst_commit",1,0,0,0,0,0, 1,0,0,0);
      apply("auto_on",        1,0,0,0,0,1, 1,0,0,1);
      apply("auto_off",       1,0,0,0,0,0, 1,0,0,0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
